// File: rtl/ma_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the load/store funct3 encodings.
package ma_stage_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    // Halfword codes share funct3[1:0]=01 (LH/LHU/SH).
    function automatic logic is_half(input logic [2:0] code);
        return code[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/ld_align.sv
// Load data extraction for the WB stage.
// Selects the byte/half lane and sign- or zero-extends.
module ld_align
    import ma_stage_pkg::*;
(
    input  logic [2:0]  ldst_code,
    input  logic [1:0]  adr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane, then extend it per the load code.
    always_comb begin
        lane_b = word[{adr_lo, 3'b000} +: 8];
        lane_h = adr_lo[1] ? word[31:16] : word[15:0];
        data   = word;
        case (ldst_code)
            LDST_B:  data = {{24{lane_b[7]}}, lane_b};
            LDST_H:  data = {{16{lane_h[15]}}, lane_h};
            LDST_BU: data = {24'h0, lane_b};
            LDST_HU: data = {16'h0, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: data-memory strobes, store lanes, MA->WB regs.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses.
module ma_stage
    import ma_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    input  logic        stall,
    input  logic        rst_pipe,
    output logic [29:0] dm_adr,
    output logic        dm_re,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  rd_adr_wb,
    output logic        wbk_rd_reg_wb,
    output logic [31:0] wbk_data_wb,
    output logic [31:0] wbk_data_wb2,
    output logic        misalign_ma
);

    logic [1:0]  adr_lo;
    logic        go;
    logic        ld_wb;
    logic [2:0]  code_wb;
    logic [1:0]  adr_lo_wb;
    logic [31:0] rdata_wb;
    logic        hold;
    logic [31:0] hold_word;
    logic [31:0] ld_word;
    logic [31:0] ld_data;

    assign adr_lo = rd_data_ma[1:0];
    assign dm_adr = rd_data_ma[31:2];

`ifdef MISALIGN_TRAP_EN
    assign misalign_ma = (cmd_ld_ma | cmd_st_ma) &
                         ((is_half(ldst_code_ma) & adr_lo[0]) |
                          ((ldst_code_ma == LDST_W) & (|adr_lo)));
`else
    assign misalign_ma = 1'b0;
`endif

    assign go    = rst_n & ~stall & ~rst_pipe & ~misalign_ma;
    assign dm_re = cmd_ld_ma & go;
    assign dm_we = cmd_st_ma & go;

    // Store byte enables and lane-replicated write data.
    always_comb begin
        dm_be    = 4'b0000;
        dm_wdata = st_data_ma;
        case (ldst_code_ma)
            LDST_B: begin
                dm_be    = 4'b0001 << adr_lo;
                dm_wdata = {4{st_data_ma[7:0]}};
            end
            LDST_H: begin
                dm_be    = adr_lo[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{st_data_ma[15:0]}};
            end
            LDST_W:  dm_be = 4'b1111;
            default: dm_be = 4'b0000;
        endcase
    end

    // MA->WB pipeline registers; flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_adr_wb     <= 5'd0;
            wbk_rd_reg_wb <= 1'b0;
            ld_wb         <= 1'b0;
            code_wb       <= 3'd0;
            adr_lo_wb     <= 2'd0;
            rdata_wb      <= 32'd0;
        end else if (rst_pipe) begin
            wbk_rd_reg_wb <= 1'b0;
            ld_wb         <= 1'b0;
        end else if (!stall) begin
            rd_adr_wb     <= rd_adr_ma;
            wbk_rd_reg_wb <= wbk_rd_reg_ma & ~misalign_ma;
            ld_wb         <= cmd_ld_ma & ~misalign_ma;
            code_wb       <= ldst_code_ma;
            adr_lo_wb     <= adr_lo;
            rdata_wb      <= rd_data_ma;
        end
    end

    // Keep the load word alive while WB is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= 1'b0;
            hold_word <= 32'd0;
        end else if (rst_pipe || !stall) begin
            hold <= 1'b0;
        end else if (ld_wb && !hold) begin
            hold      <= 1'b1;
            hold_word <= dm_rdata;
        end
    end

    assign ld_word = hold ? hold_word : dm_rdata;

    ld_align u_ld_align (
        .ldst_code (code_wb),
        .adr_lo    (adr_lo_wb),
        .word      (ld_word),
        .data      (ld_data)
    );

    assign wbk_data_wb = ld_wb ? ld_data : rdata_wb;

    // Older writeback slot for the forwarding network.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbk_data_wb2 <= 32'd0;
        end else if (rst_pipe) begin
            wbk_data_wb2 <= 32'd0;
        end else if (!stall) begin
            wbk_data_wb2 <= wbk_data_wb;
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: vector table with a WB scoreboard
// plus hand sequences for stall hold, flush, reset and misalignment.
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_ld_ma, cmd_st_ma;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma;
    logic        wbk_rd_reg_ma;
    logic [31:0] st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        stall, rst_pipe;
    logic [29:0] dm_adr;
    logic        dm_re, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [4:0]  rd_adr_wb;
    logic        wbk_rd_reg_wb;
    logic [31:0] wbk_data_wb, wbk_data_wb2;
    logic        misalign_ma;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ma_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_ld_ma     (cmd_ld_ma),
        .cmd_st_ma     (cmd_st_ma),
        .rd_adr_ma     (rd_adr_ma),
        .rd_data_ma    (rd_data_ma),
        .wbk_rd_reg_ma (wbk_rd_reg_ma),
        .st_data_ma    (st_data_ma),
        .ldst_code_ma  (ldst_code_ma),
        .stall         (stall),
        .rst_pipe      (rst_pipe),
        .dm_adr        (dm_adr),
        .dm_re         (dm_re),
        .dm_we         (dm_we),
        .dm_be         (dm_be),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .rd_adr_wb     (rd_adr_wb),
        .wbk_rd_reg_wb (wbk_rd_reg_wb),
        .wbk_data_wb   (wbk_data_wb),
        .wbk_data_wb2  (wbk_data_wb2),
        .misalign_ma   (misalign_ma)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  code;
        logic [31:0] adr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        wen;
        logic [4:0]  rd;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wb;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wb;
    } exp_t;

    localparam int NV = 15;
    vec_t vt[NV];
    exp_t q[$];
    exp_t e;
    logic [31:0] prev_wb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        cmd_ld_ma     = 1'b0;
        cmd_st_ma     = 1'b0;
        rd_adr_ma     = 5'd0;
        rd_data_ma    = 32'd0;
        wbk_rd_reg_ma = 1'b0;
        st_data_ma    = 32'd0;
        ldst_code_ma  = 3'd0;
    endtask

    task automatic drive(input logic ld, input logic st,
                         input logic [2:0] code, input logic [31:0] adr,
                         input logic [31:0] sdata, input logic wen,
                         input logic [4:0] rd);
        cmd_ld_ma     = ld;
        cmd_st_ma     = st;
        ldst_code_ma  = code;
        rd_data_ma    = adr;
        st_data_ma    = sdata;
        wbk_rd_reg_ma = wen;
        rd_adr_ma     = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ld  st  code     adr       sdata         rdata         wen rd  be       wdata         wb
        vt[0]  = '{0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 1,  4'b1000, 32'hA5A5A5A5, 32'h103};
        vt[1]  = '{1, 0, 3'b000, 32'h102, 32'h0,        32'h1280FF34, 1, 2,  4'b0000, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{1, 0, 3'b100, 32'h102, 32'h0,        32'h1280FF34, 1, 3,  4'b0000, 32'h0,        32'h00000080};
        vt[3]  = '{1, 0, 3'b001, 32'h202, 32'h0,        32'h80010000, 1, 4,  4'b0000, 32'h0,        32'hFFFF8001};
        vt[4]  = '{1, 0, 3'b101, 32'h200, 32'h0,        32'h80017FFE, 1, 5,  4'b0000, 32'h0,        32'h00007FFE};
        vt[5]  = '{1, 0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 1, 6,  4'b0000, 32'h0,        32'hDEADBEEF};
        vt[6]  = '{0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        0, 0,  4'b1100, 32'hABCDABCD, 32'h102};
        vt[7]  = '{0, 1, 3'b001, 32'h100, 32'h1234ABCD, 32'h0,        0, 0,  4'b0011, 32'hABCDABCD, 32'h100};
        vt[8]  = '{0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0,        0, 0,  4'b1111, 32'hCAFEF00D, 32'h200};
        vt[9]  = '{0, 0, 3'b000, 32'h11,  32'h0,        32'h0,        1, 7,  4'b0000, 32'h0,        32'h11};
        vt[10] = '{0, 0, 3'b000, 32'h22,  32'h0,        32'h0,        1, 8,  4'b0000, 32'h0,        32'h22};
        vt[11] = '{0, 1, 3'b011, 32'h300, 32'h55667788, 32'h0,        0, 0,  4'b0000, 32'h55667788, 32'h300};
        vt[12] = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 9,  4'b0000, 32'h0,        32'h0000007F};
        vt[13] = '{1, 0, 3'b110, 32'h100, 32'h0,        32'h87654321, 1, 10, 4'b0000, 32'h0,        32'h87654321};
        vt[14] = '{0, 1, 3'b000, 32'h100, 32'h00000012, 32'h0,        0, 0,  4'b0001, 32'h12121212, 32'h100};

        rst_n    = 1'b0;
        stall    = 1'b1;
        rst_pipe = 1'b0;
        dm_rdata = 32'hFFFFFFFF;
        drive(1, 1, 3'b010, 32'h100, 32'h1, 1, 5'd1);
        @(negedge clk);
        chk("rst_dm_re", {31'd0, dm_re}, 32'd0);
        chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
        chk("rst_wen_wb", {31'd0, wbk_rd_reg_wb}, 32'd0);
        chk("rst_rd_wb", {27'd0, rd_adr_wb}, 32'd0);
        chk("rst_wb", wbk_data_wb, 32'd0);
        chk("rst_wb2", wbk_data_wb2, 32'd0);

        next_cycle();
        idle();
        stall    = 1'b0;
        dm_rdata = 32'd0;
        rst_n    = 1'b1;
        next_cycle();

        prev_wb = 32'd0;
        for (int i = 0; i <= NV; i++) begin
            next_cycle();
            if (i < NV) begin
                drive(vt[i].ld, vt[i].st, vt[i].code, vt[i].adr,
                      vt[i].sdata, vt[i].wen, vt[i].rd);
                q.push_back('{vt[i].wen, vt[i].rd, vt[i].wb});
            end else begin
                idle();
            end
            if (i > 0) dm_rdata = vt[i-1].rdata;
            else       dm_rdata = 32'd0;
            @(negedge clk);
            if (i < NV) begin
                chk($sformatf("v%0d_dm_adr", i), {2'b00, dm_adr},
                    {2'b00, vt[i].adr[31:2]});
                chk($sformatf("v%0d_dm_re", i), {31'd0, dm_re},
                    {31'd0, vt[i].ld});
                chk($sformatf("v%0d_dm_we", i), {31'd0, dm_we},
                    {31'd0, vt[i].st});
                chk($sformatf("v%0d_misalign", i), {31'd0, misalign_ma}, 32'd0);
                if (vt[i].st) begin
                    chk($sformatf("v%0d_dm_be", i), {28'd0, dm_be},
                        {28'd0, vt[i].be});
                    chk($sformatf("v%0d_dm_wdata", i), dm_wdata, vt[i].wdata);
                end
            end
            if (i > 0) begin
                e = q.pop_front();
                chk($sformatf("v%0d_wb", i - 1), wbk_data_wb, e.wb);
                chk($sformatf("v%0d_wen_wb", i - 1), {31'd0, wbk_rd_reg_wb},
                    {31'd0, e.wen});
                chk($sformatf("v%0d_rd_wb", i - 1), {27'd0, rd_adr_wb},
                    {27'd0, e.rd});
                chk($sformatf("v%0d_wb2", i - 1), wbk_data_wb2, prev_wb);
                prev_wb = e.wb;
            end
        end

        // Load held in WB across a 3-cycle stall while dm_rdata changes.
        next_cycle();
        drive(1, 0, 3'b001, 32'h202, 32'h0, 1, 5'd4);
        next_cycle();
        idle();
        stall    = 1'b1;
        dm_rdata = 32'h80010000;
        @(negedge clk);
        chk("hold_c1_wb", wbk_data_wb, 32'hFFFF8001);
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            dm_rdata = 32'h0;
            @(negedge clk);
            chk($sformatf("hold_c%0d_wb", c), wbk_data_wb, 32'hFFFF8001);
        end
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        chk("hold_release_wb", wbk_data_wb, 32'hFFFF8001);
        next_cycle();
        @(negedge clk);
        chk("hold_after_wb2", wbk_data_wb2, 32'hFFFF8001);

        // Flush with a load in MA while stalled.
        next_cycle();
        drive(0, 0, 3'b000, 32'h55, 32'h0, 1, 5'd7);
        next_cycle();
        drive(1, 0, 3'b010, 32'h104, 32'h0, 1, 5'd8);
        stall    = 1'b1;
        rst_pipe = 1'b1;
        @(negedge clk);
        chk("flush_dm_re", {31'd0, dm_re}, 32'd0);
        chk("flush_pre_wen", {31'd0, wbk_rd_reg_wb}, 32'd1);
        next_cycle();
        idle();
        stall    = 1'b0;
        rst_pipe = 1'b0;
        @(negedge clk);
        chk("flush_wen_wb", {31'd0, wbk_rd_reg_wb}, 32'd0);
        chk("flush_wb2", wbk_data_wb2, 32'd0);

        // Reset arriving while a load sits in WB.
        next_cycle();
        drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 5'd3);
        next_cycle();
        idle();
        #2;
        rst_n    = 1'b0;
        dm_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rstld_wen_wb", {31'd0, wbk_rd_reg_wb}, 32'd0);
        chk("rstld_wb", wbk_data_wb, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstld_rel_wen", {31'd0, wbk_rd_reg_wb}, 32'd0);
        chk("rstld_rel_wb", wbk_data_wb, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rstld_post_wen", {31'd0, wbk_rd_reg_wb}, 32'd0);

        // Misaligned word store.
        next_cycle();
        dm_rdata = 32'd0;
        drive(0, 1, 3'b010, 32'h102, 32'h11223344, 0, 5'd0);
        @(negedge clk);
        chk("mis_dm_adr", {2'b00, dm_adr}, 32'h40);
`ifdef MISALIGN_TRAP_EN
        chk("mis_flag", {31'd0, misalign_ma}, 32'd1);
        chk("mis_dm_we", {31'd0, dm_we}, 32'd0);
`else
        chk("mis_flag", {31'd0, misalign_ma}, 32'd0);
        chk("mis_dm_we", {31'd0, dm_we}, 32'd1);
        chk("mis_dm_be", {28'd0, dm_be}, 32'hF);
`endif
        next_cycle();
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 clk  input  1  pipeline clock; every register samples on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 cmd_ld_ma / cmd_st_ma  input  1 each  load / store present in the MA stage.
REQ-004 rd_adr_ma  input  5  destination register.
REQ-005 rd_data_ma  input  32  ALU result; this is the effective address for ld/st.
REQ-006 wbk_rd_reg_ma  input  1  writeback enable.
REQ-007 st_data_ma  input  32  store source data.
REQ-008 ldst_code_ma  input  3  funct3 of the ld/st instruction.
REQ-009 stall / rst_pipe  input  1 each  pipeline hold / synchronous pipeline flush.
REQ-010 dm_adr  output  30  word address, equal to rd_data_ma[31:2].
REQ-011 dm_re / dm_we  output  1 each  data-memory read / write strobe.
REQ-012 dm_be  output  4  write byte enables.
REQ-013 dm_wdata  output  32  lane-replicated store data.
REQ-014 dm_rdata  input  32  read data, valid exactly one cycle after dm_re.
REQ-015 rd_adr_wb / wbk_rd_reg_wb  output  5 / 1  WB-stage destination register and writeback enable.
REQ-016 wbk_data_wb  output  32  WB writeback data, also used as forwarding source.
REQ-017 wbk_data_wb2  output  32  writeback data one retired slot older, used as forwarding source.
REQ-018 misalign_ma  output  1  misaligned access detected in MA; tied 0 without the macro.

Function
REQ-019 dm_re SHALL be cmd_ld_ma & ~stall & ~rst_pipe.
REQ-020 dm_we SHALL be cmd_st_ma & ~stall & ~rst_pipe.
REQ-021 Store byte enables and data, by ldst_code_ma:
- 000 (SB): dm_be = 1 << adr[1:0]; byte replicated x4.
- 001 (SH): dm_be = adr[1] ? 1100 : 0011; half replicated x2.
- 010 (SW): dm_be = 1111; full word.
- other codes: dm_be = 0000.
REQ-022 MA->WB registers (rd_adr_wb, wbk_rd_reg_wb, load flag, ldst code, adr[1:0], rd_data) SHALL update only when ~stall.
REQ-023 Load extraction in WB, from the buffered adr[1:0]:
- 000 LB: sign-extend.
- 001 LH: sign-extend.
- 010 LW: full word.
- 100 LBU: zero-extend.
- 101 LHU: zero-extend.
- 011/110/111: treated as LW.
REQ-024 wbk_data_wb SHALL be the extracted load data for loads and the registered rd_data for everything else; it is combinational from the WB registers.
REQ-025 Hold buffer: on the first stall cycle with a load in WB, dm_rdata SHALL be captured and a hold flag set; while the flag is set, extraction SHALL use the captured word; the flag clears on the first ~stall cycle.
REQ-026 wbk_data_wb2 SHALL load wbk_data_wb on every ~stall cycle; its latency to wbk_data_wb is one cycle.
REQ-027 rst_pipe SHALL take priority over stall and SHALL clear wbk_rd_reg_wb, the load flag, the hold flag and wbk_data_wb2 on the next edge.
REQ-028 When stall and rst_pipe are asserted together, rst_pipe wins and no memory strobe is issued.

Reset
REQ-029 While rst_n=0, every register and registered output SHALL be 0, and dm_re=dm_we=0.
REQ-030 Reset asserted mid-load SHALL discard the pending dm_rdata; no writeback SHALL occur after release.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined, a misaligned access SHALL assert misalign_ma combinationally and suppress that access's memory strobe and its writeback enable:
- halfword with adr[0]=1;
- word with adr[1:0]!=0.
REQ-032 With MISALIGN_TRAP_EN undefined:
- misalign_ma SHALL be 0;
- word accesses ignore adr[1:0];
- halfword accesses use adr[1] only.

Structure
REQ-033 The shared package SHALL hold the ldst_code constants (LDST_B=000, LDST_H=001, LDST_W=010, LDST_BU=100, LDST_HU=101).
REQ-034 Load extraction SHALL be a combinational sub-module named ld_align.

Verification
REQ-035 Scenario: SB, adr=0x103, data=0x000000A5 -> dm_be=1000, dm_wdata=0xA5A5A5A5, dm_adr=0x40, dm_we for 1 cycle.
REQ-036 Scenario: LB, adr=0x102, dm_rdata=0x1280FF34 -> wbk_data_wb=0xFFFFFF80; LBU -> 0x00000080.
REQ-037 Scenario: LH, adr=0x202, dm_rdata=0x8001_0000, stall held 3 cycles while in WB, dm_rdata changed to 0 -> wbk_data_wb remains 0xFFFF8001 throughout.
REQ-038 Scenario: ALU result 0x11 followed by 0x22 -> wbk_data_wb2 equals 0x11 in the cycle wbk_data_wb equals 0x22.
REQ-039 Scenario: rst_pipe asserted with a load in MA and stall=1 -> dm_re=0, wbk_rd_reg_wb=0 next cycle.
REQ-040 Scenario: MISALIGN_TRAP_EN defined, SW adr=0x102 -> misalign_ma=1, dm_we=0; undefined -> dm_we=1, dm_be=1111, dm_adr=0x40.
